// File: rtl/calc_pkg.sv
// Shared types and helpers for the parametrised calculator core:
// keypad command codes, status/state encodings and the operator register type.
package calc_pkg;

    localparam int NDIG_DEFAULT = 8;

    // Digit commands 0..9 are the raw code values; only the control keys are named.
    typedef enum logic [3:0] {
        CMD_ADD  = 4'hA,
        CMD_SUB  = 4'hB,
        CMD_MUL  = 4'hC,
        CMD_CLR  = 4'hD,
        CMD_EQ   = 4'hE,
        CMD_BKSP = 4'hF
    } cmd_e;

    typedef enum logic [1:0] {
        STAT_ERROR    = 2'b00,
        STAT_BUSY     = 2'b01,
        STAT_READY    = 2'b10,
        STAT_PRINTING = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        ST_WAIT_A = 3'd0,
        ST_OP     = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_CALC   = 3'd3,
        ST_PRINT  = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_e;

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic op_e cmd_to_op(input logic [3:0] c);
        case (c)
            CMD_ADD: return OP_ADD;
            CMD_SUB: return OP_SUB;
            CMD_MUL: return OP_MUL;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/calc_digit_serializer.sv
// Emits the NDIG decimal digits of a value, least significant first, one per cycle,
// using a single divide-by-10 on the running quotient.
module calc_digit_serializer
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT,
    parameter int VW   = 27
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [VW-1:0]           value,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic                    done
);

    localparam int PW = $clog2(NDIG);

    logic [VW-1:0] rem_reg;
    logic [3:0]    data_reg;
    logic [PW-1:0] pos_reg;
    logic          busy_reg;

    logic [VW-1:0] src;
    logic [VW-1:0] quo;
    logic [3:0]    dig;

    // Digit 0 is produced straight from the loaded value so it appears the cycle after start.
    assign src = start ? value : rem_reg;
    assign quo = src / VW'(10);
    assign dig = 4'(src % VW'(10));

    assign done = busy_reg && (pos_reg == PW'(NDIG - 1));
    assign data = data_reg;
    assign pos  = pos_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_reg  <= '0;
            data_reg <= '0;
            pos_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= quo;
            data_reg <= dig;
            pos_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            if (done) begin
                data_reg <= '0;
                pos_reg  <= '0;
                busy_reg <= 1'b0;
            end else begin
                rem_reg  <= quo;
                data_reg <= dig;
                pos_reg  <= pos_reg + PW'(1);
            end
        end
    end

endmodule

// File: rtl/calc_param.sv
// Calculator core: decimal operand entry, + - * (shift-add, fixed latency), overflow
// detection and a serialised digit stream for the display controller.
module calc_param
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              cmd,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [1:0]              status,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic                    neg,
    output logic [2:0]              state
);

    localparam int W  = $clog2(pow10(NDIG)) + 1;
    localparam int M  = W - 1;
    localparam int CW = $clog2(M);
    localparam logic [M-1:0] MAX_VAL   = M'(pow10(NDIG) - 1);
    localparam logic [M-1:0] ENTRY_LIM = M'(pow10(NDIG - 1));

    state_e         state_reg, state_next;
    state_e         ret_reg, ret_next;
    op_e            op_reg, op_next;
    logic [M-1:0]   acc_reg, acc_next;
    logic [M-1:0]   a_reg, a_next;
    logic [M-1:0]   b_reg, b_next;
    logic           neg_reg, neg_next;
    logic [2*M-1:0] prod_reg, prod_next;
    logic [2*M-1:0] mcand_reg, mcand_next;
    logic [M-1:0]   mplier_reg, mplier_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    logic           ser_start;
    logic [M-1:0]   ser_value;
    logic [3:0]     ser_data;
    logic           ser_done;

    logic           accept, is_digit, is_op;
    logic [M-1:0]   acc_dig, acc_div;
    logic [M:0]     sum;
    logic           b_gt_a;
    logic [M-1:0]   diff;
    logic [2*M-1:0] prod_sum;
    logic           mul_last;

    logic           calc_done, calc_ovf, calc_neg;
    logic [M-1:0]   calc_val;

    // Clear must still reach the core while it sits in ERROR, so ready only drops when busy/printing.
    assign cmd_ready = (state_reg != ST_CALC) && (state_reg != ST_PRINT);
    assign accept    = cmd_valid && cmd_ready;
    assign is_digit  = cmd < 4'd10;
    assign is_op     = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);

    assign acc_dig  = acc_reg * M'(10) + M'(cmd);
    assign acc_div  = acc_reg / M'(10);
    assign sum      = {1'b0, a_reg} + {1'b0, b_reg};
    assign b_gt_a   = b_reg > a_reg;
    assign diff     = b_gt_a ? (b_reg - a_reg) : (a_reg - b_reg);
    assign prod_sum = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_last = cnt_reg == CW'(M - 1);

    always_comb begin
        calc_done = 1'b0;
        calc_ovf  = 1'b0;
        calc_neg  = 1'b0;
        calc_val  = '0;
        case (op_reg)
            OP_ADD: begin
                calc_done = 1'b1;
                calc_ovf  = sum > {1'b0, MAX_VAL};
                calc_val  = sum[M-1:0];
            end
            OP_SUB: begin
                calc_done = 1'b1;
                calc_neg  = b_gt_a;
                calc_val  = diff;
            end
            OP_MUL: begin
                calc_done = mul_last;
                calc_ovf  = prod_sum > {{M{1'b0}}, MAX_VAL};
                calc_val  = prod_sum[M-1:0];
            end
            default: begin
                calc_done = 1'b1;
                calc_val  = acc_reg;
            end
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        ret_next    = ret_reg;
        op_next     = op_reg;
        acc_next    = acc_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        neg_next    = neg_reg;
        prod_next   = prod_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        ser_start   = 1'b0;
        ser_value   = acc_reg;

        if (accept && cmd == CMD_CLR) begin
            state_next  = ST_WAIT_A;
            ret_next    = ST_WAIT_A;
            op_next     = OP_NONE;
            acc_next    = '0;
            a_next      = '0;
            b_next      = '0;
            neg_next    = 1'b0;
            prod_next   = '0;
            mcand_next  = '0;
            mplier_next = '0;
            cnt_next    = '0;
        end else begin
            case (state_reg)
                ST_WAIT_A, ST_WAIT_B: begin
                    if (accept) begin
                        if (is_digit) begin
                            if (acc_reg < ENTRY_LIM) begin
                                acc_next   = acc_dig;
                                ser_value  = acc_dig;
                                ser_start  = 1'b1;
                                neg_next   = 1'b0;
                                ret_next   = state_reg;
                                state_next = ST_PRINT;
                            end
                        end else if (cmd == CMD_BKSP) begin
                            acc_next   = acc_div;
                            ser_value  = acc_div;
                            ser_start  = 1'b1;
                            neg_next   = 1'b0;
                            ret_next   = state_reg;
                            state_next = ST_PRINT;
                        end else if (is_op && state_reg == ST_WAIT_A) begin
                            a_next     = acc_reg;
                            op_next    = cmd_to_op(cmd);
                            acc_next   = '0;
                            neg_next   = 1'b0;
                            state_next = ST_OP;
                        end else if (cmd == CMD_EQ && state_reg == ST_WAIT_B) begin
                            // Operand B becomes the multiplier; A is shifted up one place per cycle.
                            b_next      = acc_reg;
                            prod_next   = '0;
                            mcand_next  = {{M{1'b0}}, a_reg};
                            mplier_next = acc_reg;
                            cnt_next    = '0;
                            state_next  = ST_CALC;
                        end
                    end
                end
                ST_OP: begin
                    if (accept) begin
                        if (is_digit) begin
                            acc_next   = M'(cmd);
                            ser_value  = M'(cmd);
                            ser_start  = 1'b1;
                            ret_next   = ST_WAIT_B;
                            state_next = ST_PRINT;
                        end else if (is_op) begin
                            op_next = cmd_to_op(cmd);
                        end
                    end
                end
                ST_CALC: begin
                    if (op_reg == OP_MUL) begin
                        prod_next   = prod_sum;
                        mcand_next  = mcand_reg << 1;
                        mplier_next = mplier_reg >> 1;
                        cnt_next    = cnt_reg + CW'(1);
                    end
                    if (calc_done) begin
                        if (calc_ovf) begin
                            state_next = ST_ERROR;
                        end else begin
                            acc_next   = calc_val;
                            neg_next   = calc_neg;
                            ser_value  = calc_val;
                            ser_start  = 1'b1;
                            ret_next   = ST_WAIT_A;
                            state_next = ST_PRINT;
                        end
                    end
                end
                ST_PRINT: begin
                    if (ser_done) begin
                        state_next = ret_reg;
                    end
                end
                ST_ERROR: begin
                end
                default: begin
                    state_next = ST_WAIT_A;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_WAIT_A;
            ret_reg    <= ST_WAIT_A;
            op_reg     <= OP_NONE;
            acc_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            neg_reg    <= 1'b0;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            ret_reg    <= ret_next;
            op_reg     <= op_next;
            acc_reg    <= acc_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            neg_reg    <= neg_next;
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    calc_digit_serializer #(
        .NDIG (NDIG),
        .VW   (M)
    ) u_serializer (
        .clock (clock),
        .reset (reset),
        .start (ser_start),
        .value (ser_value),
        .data  (ser_data),
        .pos   (pos),
        .done  (ser_done)
    );

    always_comb begin
        case (state_reg)
            ST_CALC:  status = STAT_BUSY;
            ST_PRINT: status = STAT_PRINTING;
            ST_ERROR: status = STAT_ERROR;
            default:  status = STAT_READY;
        endcase
    end

    assign data  = (state_reg == ST_ERROR) ? 4'hE : ser_data;
    assign neg   = neg_reg;
    assign state = state_reg;

endmodule
